// File: rtl/stuff_serializer_tx_if.sv
// stuff_serializer_tx_if: word handshake and serial line bundle for the bit-stuffing transmitter
interface stuff_serializer_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              s;
    logic              s_valid;
    logic              stuffed;
    logic              busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, s, s_valid, stuffed, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, s, s_valid, stuffed, busy
    );
endinterface

// File: rtl/stuff_serializer_tx.sv
// stuff_serializer_tx: MSB-first serializer inserting a complement bit after every run of MAX_RUN equal bits
module stuff_serializer_tx #(
    parameter int DATA_W  = 8,
    parameter int MAX_RUN = 3
) (
    input logic                  clk,
    input logic                  reset,
    stuff_serializer_tx_if.slave bus
);
    localparam int RW = $clog2(MAX_RUN + 1);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, STUFF} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [RW-1:0]     run_q, run_d;
    logic              s_q, s_d;
    logic              sv_q, sv_d;
    logic              stf_q, stf_d;
    logic              busy_q;

    logic              stuff_due;
    logic              ready;
    logic              accept;
    logic [DATA_W-1:0] src;
    logic              bit_n;
    logic [RW-1:0]     run_n;

    // state_q names what is on the line now; run_q/last_q already include the bit being shown
    assign stuff_due = (state_q == SHIFT) && (run_q == RW'(MAX_RUN));
    assign ready     = (state_q == IDLE) || (!stuff_due && cnt_q == '0);
    assign accept    = bus.in_valid && ready;
    assign src       = accept ? bus.in_data : sh_q;
    assign bit_n     = src[DATA_W-1];
    assign run_n     = (run_q != '0 && bit_n == last_q) ? run_q + 1'b1 : RW'(1);

    // next line bit: pending stuff first, then idle when the word ends unfed, else the next data bit
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        run_d   = run_q;
        s_d     = s_q;
        sv_d    = sv_q;
        stf_d   = 1'b0;
        if (stuff_due) begin
            state_d = STUFF;
            s_d     = ~last_q;
            last_d  = ~last_q;
            run_d   = RW'(1);
            sv_d    = 1'b1;
            stf_d   = 1'b1;
        end else if (ready && !accept) begin
            state_d = IDLE;
            sh_d    = '0;
            cnt_d   = '0;
            last_d  = 1'b0;
            run_d   = '0;
            s_d     = 1'b0;
            sv_d    = 1'b0;
        end else begin
            state_d = SHIFT;
            sh_d    = src << 1;
            cnt_d   = accept ? CW'(DATA_W - 1) : cnt_q - 1'b1;
            last_d  = bit_n;
            run_d   = run_n;
            s_d     = bit_n;
            sv_d    = 1'b1;
        end
    end

    // registered state and line outputs, dropped immediately on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            run_q   <= '0;
            s_q     <= 1'b0;
            sv_q    <= 1'b0;
            stf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            run_q   <= run_d;
            s_q     <= s_d;
            sv_q    <= sv_d;
            stf_q   <= stf_d;
            busy_q  <= sv_d;
        end
    end

    assign bus.in_ready = ready;
    assign bus.s        = s_q;
    assign bus.s_valid  = sv_q;
    assign bus.stuffed  = stf_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_stuff_serializer_tx.sv
// tb_stuff_serializer_tx: directed and random checks of the bit-stuffing serializer with a de-stuffing scoreboard
module tb_stuff_serializer_tx;
    localparam int DW = 8;
    localparam int MR = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stuff_serializer_tx_if #(.DATA_W(DW)) ifc ();
    stuff_serializer_tx #(.DATA_W(DW), .MAX_RUN(MR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int passed = 0;
    int total  = 0;
    logic [DW-1:0] word_q[$];
    logic [2:0]    line_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_line(input logic [31:0] s, input logic [31:0] st, input logic [31:0] r, input int n);
        for (int i = n - 1; i >= 0; i--) line_q.push_back({s[i], st[i], r[i]});
    endtask

    task automatic send(input logic [DW-1:0] w, input bit keep);
        int k;
        logic r;
        k = 0;
        ifc.in_data  = w;
        ifc.in_valid = 1'b1;
        do begin
            @(negedge clk);
            r = ifc.in_ready;
            @(posedge clk);
            k++;
        end while (!r && k < 200);
        if (r) word_q.push_back(w);
        else check("accept_timeout", {31'd0, r}, 32'd1);
        #1;
        if (!keep) ifc.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (ifc.s_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain", ifc.s_valid, 0);
        check("line_q_empty", line_q.size(), 0);
        check("word_q_empty", word_q.size(), 0);
        check("idle_ready", ifc.in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #1;
        check("rst_s", ifc.s, 0);
        check("rst_s_valid", ifc.s_valid, 0);
        check("rst_stuffed", ifc.stuffed, 0);
        check("rst_busy", ifc.busy, 0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_ready", ifc.in_ready, 1);
        repeat (3) begin
            @(negedge clk);
            check("post_rst_quiet", ifc.s_valid, 0);
        end
        @(posedge clk);
        #1;
    endtask

    // scoreboard: independently re-stuffs and de-stuffs the line, checks words, flags and run length
    logic          pend, mlast, dlast;
    int            mrun, drun, nb;
    logic [DW-1:0] acc, w;
    logic [2:0]    e;
    always @(negedge clk) begin
        if (reset) begin
            pend = 1'b0;
            mlast = 1'b0;
            dlast = 1'b0;
            mrun = 0;
            drun = 0;
            nb = 0;
            acc = '0;
            word_q.delete();
            line_q.delete();
        end else begin
            check("busy", ifc.busy, ifc.s_valid);
            if (ifc.s_valid) begin
                drun = (drun != 0 && ifc.s == dlast) ? drun + 1 : 1;
                dlast = ifc.s;
                check("run_detector", {31'd0, drun <= MR}, 1);
                if (line_q.size() > 0) begin
                    e = line_q.pop_front();
                    check("line", {ifc.s, ifc.stuffed, ifc.in_ready}, e);
                end
                if (pend) begin
                    check("stuff_bit", {ifc.stuffed, ifc.s}, {1'b1, ~mlast});
                    mlast = ifc.s;
                    mrun = 1;
                    pend = 1'b0;
                end else begin
                    check("data_flag", ifc.stuffed, 0);
                    mrun = (mrun != 0 && ifc.s == mlast) ? mrun + 1 : 1;
                    mlast = ifc.s;
                    acc = {acc[DW-2:0], ifc.s};
                    nb++;
                    if (mrun == MR) pend = 1'b1;
                    if (nb == DW) begin
                        nb = 0;
                        check("word_expected", {31'd0, word_q.size() > 0}, 1);
                        if (word_q.size() > 0) begin
                            w = word_q.pop_front();
                            check("word", acc, w);
                        end
                    end
                end
            end else begin
                check("idle_s", ifc.s, 0);
                check("idle_stuff_pending", pend, 0);
                check("idle_partial", nb, 0);
                mrun = 0;
                drun = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("init_s", ifc.s, 0);
        check("init_s_valid", ifc.s_valid, 0);
        check("init_busy", ifc.busy, 0);
        check("init_ready", ifc.in_ready, 1);

        ifc.in_data  = 8'hFF;
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
        word_q.push_back(8'hFF);
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        reset_pulse();

        push_line(32'b10100101, 32'b0, 32'b00000001, 8);
        send(8'hA5, 1'b0);
        wait_idle();

        push_line(32'b1110111011, 32'b0001000100, 32'b0000000001, 10);
        send(8'hFF, 1'b0);
        wait_idle();

        push_line(32'b00010111011101100010, 32'b00010000100010000010, 32'b00000000010000000001, 20);
        send(8'h0F, 1'b1);
        send(8'hF0, 1'b0);
        wait_idle();

        ifc.in_data  = 8'h00;
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
        word_q.push_back(8'h00);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        reset_pulse();
        push_line(32'b10100101, 32'b0, 32'b00000001, 8);
        send(8'hA5, 1'b0);
        wait_idle();

        for (int i = 0; i < 60; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            send(DW'($urandom), gap == 0);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        ifc.in_valid = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
